// File: rtl/argmax_accum.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_accum
//  Purpose  : Sequential argmax stage that sits after the 16-lane max tree.
//             Each beat carries one {local_index, signed value} winner. The
//             block folds num_beats beats into one global {index, value}
//             maximum and presents it on a valid/ready result port.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start, num_beats      - begin a reduction of num_beats beats
//             busy                  - high while a reduction is open
//             in_valid/in_ready     - beat handshake; in_data = {idx, value}
//             out_valid/out_ready   - result handshake
//             out_index, out_value  - global index and value of the maximum
//  Config   : ARGMAX_TIE_LAST_EN    - when defined, ties report the latest
//                                     index (>=); default is earliest (>)
//  Revision : 1.0  initial release
// ============================================================================
module argmax_accum #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 16,
  parameter int LANES       = 16,   // must be a power of two
  parameter int LEN_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              num_beats,
  output logic                              busy,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [INDEX_WIDTH-1:0]            out_index,
  output logic [DATA_WIDTH-1:0]             out_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int                    c_SHIFT    = $clog2(LANES);
  localparam int                    c_WIDE     = LEN_WIDTH + INDEX_WIDTH;
  localparam logic [DATA_WIDTH-1:0] c_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0]  c_ONE      = LEN_WIDTH'(1);

  state_t                 r_state;
  logic [LEN_WIDTH-1:0]   r_num_beats;
  logic [LEN_WIDTH-1:0]   r_beat_cnt;
  logic [DATA_WIDTH-1:0]  r_best_val;
  logic [INDEX_WIDTH-1:0] r_best_idx;

  logic [DATA_WIDTH-1:0]  w_beat_val;
  logic [INDEX_WIDTH-1:0] w_local_idx;
  logic [c_WIDE-1:0]      w_base_wide;
  logic [INDEX_WIDTH-1:0] w_gidx;
  logic                   w_first;
  logic                   w_better;
  logic                   w_take;
  logic                   w_last;
  logic [DATA_WIDTH-1:0]  w_new_val;
  logic [INDEX_WIDTH-1:0] w_new_idx;

  assign w_beat_val  = in_data[DATA_WIDTH-1:0];
  assign w_local_idx = in_data[INDEX_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  // beat_cnt*LANES as a shift; the wide intermediate is truncated so the
  // global index wraps modulo 2^INDEX_WIDTH.
  assign w_base_wide = {{INDEX_WIDTH{1'b0}}, r_beat_cnt} << c_SHIFT;
  assign w_gidx      = w_base_wide[INDEX_WIDTH-1:0] + w_local_idx;

  assign w_first = (r_beat_cnt == '0);
`ifdef ARGMAX_TIE_LAST_EN
  assign w_better = ($signed(w_beat_val) >= $signed(r_best_val));
`else
  assign w_better = ($signed(w_beat_val) > $signed(r_best_val));
`endif
  // The first beat always loads, independent of the reset value of best.
  assign w_take    = w_first || w_better;
  assign w_new_val = w_take ? w_beat_val : r_best_val;
  assign w_new_idx = w_take ? w_gidx     : r_best_idx;
  assign w_last    = (r_beat_cnt == (r_num_beats - c_ONE));

  // Handshake/status outputs are pure decodes of the registered state.
  assign in_ready  = (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num_beats <= '0;
      r_beat_cnt  <= '0;
      r_best_val  <= c_MOST_NEG;
      r_best_idx  <= '0;
      out_index   <= '0;
      out_value   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_beats <= num_beats;
            r_beat_cnt  <= '0;
            r_best_val  <= c_MOST_NEG;
            r_best_idx  <= '0;
            if (num_beats == '0) begin
              // Empty reduction: report {0, most-negative} directly.
              r_state   <= S_DONE;
              out_index <= '0;
              out_value <= c_MOST_NEG;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_best_val <= w_new_val;
            r_best_idx <= w_new_idx;
            r_beat_cnt <= r_beat_cnt + c_ONE;
            if (w_last) begin
              // Fold the final beat straight into the result registers.
              r_state   <= S_DONE;
              out_index <= w_new_idx;
              out_value <= w_new_val;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
